// File: rtl/reg_bank.sv
// reg_bank: multi-ported register bank with two combinational read ports,
// an ALU write port and a single-outstanding load return path.
// Registers 0 and 1 read as the constants 0 and 1. A load reserves its
// destination at issue time; ALU writes to the reserved address are dropped
// and flagged on wr_conflict for one cycle.
// Optional feature: define REG_BANK_FWD_EN to forward the committing write
// data to the read ports (load data has priority over ALU data).
//
// state | meaning
// IDLE  | no load outstanding, pend_addr is don't-care
// WAIT  | one load outstanding, destination held in pend_addr
module reg_bank #(
  parameter int W   = 8,
  parameter int PW  = 3,
  parameter int DED = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [PW-1:0] wr_addr,
  input  logic [W-1:0]  dat_in,
  input  logic [PW-1:0] rd_addrA,
  input  logic [PW-1:0] rd_addrB,
  input  logic          ld_issue,
  input  logic [PW-1:0] ld_addr,
  output logic          issue_ready,
  input  logic          ld_valid,
  input  logic [W-1:0]  ld_data,
  output logic [W-1:0]  datA_out,
  output logic [W-1:0]  datB_out,
  output logic [W-1:0]  ded_out,
  output logic          busyA,
  output logic          busyB,
  output logic          wr_conflict
);

  localparam int            DEPTH    = 2 ** PW;
  localparam logic [PW-1:0] DED_ADDR = PW'(DED);
  localparam logic [PW-1:0] ADDR_ONE = PW'(1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pend_addr, pend_nxt;
  logic [W-1:0]  regs [DEPTH];

  logic ld_commit;
  logic wr_legal;
  logic wr_hit_pend;
  logic alu_commit;
  logic wr_drop;

  // A load return is only meaningful while a destination is reserved, and
  // returns aimed at the constant registers are thrown away.
  assign ld_commit   = (state == WAIT) && ld_valid && (pend_addr > ADDR_ONE);
  assign wr_legal    = wr_en && (wr_addr > ADDR_ONE);
  assign wr_hit_pend = (state == WAIT) && (wr_addr == pend_addr);
  assign alu_commit  = wr_legal && !wr_hit_pend;
  assign wr_drop     = wr_legal && wr_hit_pend;

  // A returning load frees the slot in the same cycle, so a new issue can
  // be accepted back-to-back.
  assign issue_ready = (state == IDLE) || ld_valid;

  assign busyA = (state == WAIT) && (rd_addrA == pend_addr) && (pend_addr > ADDR_ONE);
  assign busyB = (state == WAIT) && (rd_addrB == pend_addr) && (pend_addr > ADDR_ONE);

  // Load FSM state and reserved destination register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pend_addr <= '0;
    end else begin
      state     <= state_nxt;
      pend_addr <= pend_nxt;
    end
  end

  // Load FSM next-state: accept issue when idle, retire on return.
  always_comb begin
    state_nxt = state;
    pend_nxt  = pend_addr;
    case (state)
      IDLE: begin
        if (ld_issue) begin
          state_nxt = WAIT;
          pend_nxt  = ld_addr;
        end
      end
      WAIT: begin
        if (ld_valid) begin
          if (ld_issue) begin
            pend_nxt = ld_addr;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Register storage; ALU and load writes never target the same entry
  // because ALU writes to the reserved address are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (alu_commit) regs[wr_addr]   <= dat_in;
      if (ld_commit)  regs[pend_addr] <= ld_data;
    end
  end

  // Dropped-write flag, visible for exactly the cycle after the drop.
  always_ff @(posedge clk) begin
    if (reset) wr_conflict <= 1'b0;
    else       wr_conflict <= wr_drop;
  end

  function automatic logic [W-1:0] rd(input logic [PW-1:0] a);
    logic [W-1:0] v;
    if (a == '0) begin
      v = '0;
    end else if (a == ADDR_ONE) begin
      v = W'(1);
`ifdef REG_BANK_FWD_EN
    end else if (ld_commit && (a == pend_addr)) begin
      v = ld_data;
    end else if (alu_commit && (a == wr_addr)) begin
      v = dat_in;
`endif
    end else begin
      v = regs[a];
    end
    return v;
  endfunction

  assign datA_out = rd(rd_addrA);
  assign datB_out = rd(rd_addrB);
  assign ded_out  = rd(DED_ADDR);

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed vectors for reg_bank. Stimulus pushes expected
// output values into a queue each cycle; the monitor drains the queue on the
// falling edge and compares against the DUT outputs.
module tb_reg_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] dat_in;
  logic [2:0] rd_addrA;
  logic [2:0] rd_addrB;
  logic       ld_issue;
  logic [2:0] ld_addr;
  logic       issue_ready;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic [7:0] datA_out;
  logic [7:0] datB_out;
  logic [7:0] ded_out;
  logic       busyA;
  logic       busyB;
  logic       wr_conflict;

  reg_bank #(.W(8), .PW(3), .DED(2)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
    .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .ld_issue(ld_issue), .ld_addr(ld_addr), .issue_ready(issue_ready),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .datA_out(datA_out), .datB_out(datB_out), .ded_out(ded_out),
    .busyA(busyA), .busyB(busyB), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  typedef enum int {S_DATA, S_DATB, S_DED, S_BUSYA, S_BUSYB, S_IRDY, S_WCONF} sel_t;

  typedef struct {
    string      name;
    sel_t       sel;
    logic [7:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef REG_BANK_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic expect_out(input string name, input sel_t sel, input logic [7:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every queued expectation against the settled outputs.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t       e;
      logic [7:0] act;
      e = q.pop_front();
      case (e.sel)
        S_DATA:  act = datA_out;
        S_DATB:  act = datB_out;
        S_DED:   act = ded_out;
        S_BUSYA: act = {7'd0, busyA};
        S_BUSYB: act = {7'd0, busyB};
        S_IRDY:  act = {7'd0, issue_ready};
        default: act = {7'd0, wr_conflict};
      endcase
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; dat_in = '0;
    rd_addrA = '0; rd_addrB = '0; ld_issue = 1'b0; ld_addr = '0;
    ld_valid = 1'b0; ld_data = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state: all addresses read 0 except the constant 1.
    expect_out("rst_irdy",  S_IRDY,  8'h01);
    expect_out("rst_busyA", S_BUSYA, 8'h00);
    expect_out("rst_busyB", S_BUSYB, 8'h00);
    expect_out("rst_wconf", S_WCONF, 8'h00);
    expect_out("rst_ded",   S_DED,   8'h00);
    for (int a = 0; a < 8; a++) begin
      rd_addrA = 3'(a);
      rd_addrB = 3'(7 - a);
      expect_out($sformatf("rst_rdA%0d", a), S_DATA, (a == 1) ? 8'h01 : 8'h00);
      expect_out($sformatf("rst_rdB%0d", 7 - a), S_DATB, (a == 6) ? 8'h01 : 8'h00);
      tick();
    end

    // ALU write to 5, then attempted write to constant register 1.
    wr_en = 1'b1; wr_addr = 3'd5; dat_in = 8'hA5; rd_addrA = 3'd5;
    expect_out("wr5_same", S_DATA, FWD ? 8'hA5 : 8'h00);
    tick();
    wr_en = 1'b0;
    expect_out("wr5_next", S_DATA, 8'hA5);
    tick();
    wr_en = 1'b1; wr_addr = 3'd1; dat_in = 8'hFF; rd_addrA = 3'd1;
    expect_out("wr1_same", S_DATA, 8'h01);
    tick();
    wr_en = 1'b0;
    expect_out("wr1_next", S_DATA, 8'h01);
    expect_out("wr1_noconf", S_WCONF, 8'h00);
    tick();

    // Load to the dedicated register 2.
    ld_issue = 1'b1; ld_addr = 3'd2;
    expect_out("ld2_irdy", S_IRDY, 8'h01);
    tick();
    ld_issue = 1'b1; ld_addr = 3'd6; rd_addrA = 3'd2; rd_addrB = 3'd6;
    expect_out("ld2_busyA",  S_BUSYA, 8'h01);
    expect_out("ld2_irdy0",  S_IRDY,  8'h00);
    expect_out("ld2_busyB6", S_BUSYB, 8'h00);
    expect_out("ld2_old",    S_DATA,  8'h00);
    tick();
    ld_issue = 1'b0; ld_valid = 1'b1; ld_data = 8'h3C;
    expect_out("ld2_ret_irdy", S_IRDY,  8'h01);
    expect_out("ld2_ret_ded",  S_DED,   FWD ? 8'h3C : 8'h00);
    expect_out("ld2_ret_busy", S_BUSYA, 8'h01);
    tick();
    ld_valid = 1'b0;
    expect_out("ld2_ded",     S_DED,   8'h3C);
    expect_out("ld2_datA",    S_DATA,  8'h3C);
    expect_out("ld2_nobusy",  S_BUSYA, 8'h00);
    expect_out("ld6_ignored", S_BUSYB, 8'h00);
    tick();

    // Conflict on pending address 4; load plus ALU write to 6 together.
    ld_issue = 1'b1; ld_addr = 3'd4;
    tick();
    ld_issue = 1'b0; wr_en = 1'b1; wr_addr = 3'd4; dat_in = 8'h11; rd_addrA = 3'd4;
    expect_out("p4_busyA", S_BUSYA, 8'h01);
    expect_out("p4_wconf0", S_WCONF, 8'h00);
    tick();
    wr_en = 1'b0;
    expect_out("p4_wconf1", S_WCONF, 8'h01);
    expect_out("p4_dropped", S_DATA, 8'h00);
    tick();
    ld_valid = 1'b1; ld_data = 8'h22; wr_en = 1'b1; wr_addr = 3'd6; dat_in = 8'h66;
    rd_addrA = 3'd4; rd_addrB = 3'd6;
    expect_out("p4_wconf_once", S_WCONF, 8'h00);
    expect_out("p4_ld_same", S_DATA, FWD ? 8'h22 : 8'h00);
    expect_out("w6_same",    S_DATB, FWD ? 8'h66 : 8'h00);
    tick();
    ld_valid = 1'b0; wr_en = 1'b0;
    expect_out("p4_reg4", S_DATA,  8'h22);
    expect_out("w6_reg6", S_DATB,  8'h66);
    expect_out("w6_noconf", S_WCONF, 8'h00);
    expect_out("p4_free", S_BUSYA, 8'h00);
    tick();

    // Back-to-back: return to 3 with new issue to 7 and same-address ALU write.
    ld_issue = 1'b1; ld_addr = 3'd3;
    tick();
    ld_valid = 1'b1; ld_data = 8'h55; ld_issue = 1'b1; ld_addr = 3'd7;
    wr_en = 1'b1; wr_addr = 3'd3; dat_in = 8'hEE; rd_addrA = 3'd3; rd_addrB = 3'd7;
    expect_out("b2b_irdy", S_IRDY, 8'h01);
    expect_out("b2b_same", S_DATA, FWD ? 8'h55 : 8'h00);
    tick();
    ld_valid = 1'b0; ld_issue = 1'b0; wr_en = 1'b0;
    expect_out("b2b_reg3",   S_DATA,  8'h55);
    expect_out("b2b_busy3",  S_BUSYA, 8'h00);
    expect_out("b2b_busy7",  S_BUSYB, 8'h01);
    expect_out("b2b_irdy0",  S_IRDY,  8'h00);
    expect_out("b2b_wconf",  S_WCONF, 8'h01);
    tick();
    ld_valid = 1'b1; ld_data = 8'h77;
    tick();
    ld_valid = 1'b0;
    expect_out("b2b_reg7",  S_DATB,  8'h77);
    expect_out("b2b_free7", S_BUSYB, 8'h00);
    tick();

    // Load to constant register 0 is accepted, never busy, data discarded.
    ld_issue = 1'b1; ld_addr = 3'd0;
    tick();
    ld_issue = 1'b0; rd_addrA = 3'd0; wr_en = 1'b1; wr_addr = 3'd0; dat_in = 8'h5A;
    expect_out("ld0_busy", S_BUSYA, 8'h00);
    expect_out("ld0_irdy", S_IRDY,  8'h00);
    tick();
    wr_en = 1'b0; ld_valid = 1'b1; ld_data = 8'hAA;
    expect_out("ld0_wconf", S_WCONF, 8'h00);
    expect_out("ld0_same",  S_DATA,  8'h00);
    tick();
    ld_valid = 1'b0;
    expect_out("ld0_after", S_DATA, 8'h00);
    expect_out("ld0_idle",  S_IRDY, 8'h01);
    tick();

    // Reset abandons an outstanding load to 5 and overrides a write to 6.
    ld_issue = 1'b1; ld_addr = 3'd5;
    tick();
    ld_issue = 1'b0; rd_addrA = 3'd5; rd_addrB = 3'd6;
    expect_out("r5_busy", S_BUSYA, 8'h01);
    tick();
    reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd6; dat_in = 8'h12;
    tick();
    reset = 1'b0; wr_en = 1'b0;
    expect_out("r5_cleared", S_DATA,  8'h00);
    expect_out("r5_reg6",    S_DATB,  8'h00);
    expect_out("r5_nobusy",  S_BUSYA, 8'h00);
    expect_out("r5_irdy",    S_IRDY,  8'h01);
    expect_out("r5_ded",     S_DED,   8'h00);
    tick();
    ld_valid = 1'b1; ld_data = 8'h99;
    expect_out("r5_stray_same", S_DATA, 8'h00);
    tick();
    ld_valid = 1'b0;
    expect_out("r5_stray_ign", S_DATA, 8'h00);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 Parameters SHALL be, one per line:
  W  8  data width in bits
  PW  3  address width; depth = 2**PW
  DED  2  index of the dedicated register driven to ded_out
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock; all state updates on rising edge
  reset  in  1  synchronous, active-high reset
  wr_en  in  1  ALU write strobe
  wr_addr  in  PW  ALU write address
  dat_in  in  W  ALU write data
  rd_addrA  in  PW  read address, port A
  rd_addrB  in  PW  read address, port B
  ld_issue  in  1  load-issue request (reserves a destination)
  ld_addr  in  PW  load destination address
  issue_ready  out  1  high when ld_issue is accepted this cycle
  ld_valid  in  1  load data return strobe
  ld_data  in  W  load return data
  datA_out  out  W  read data, port A
  datB_out  out  W  read data, port B
  ded_out  out  W  contents of register DED
  busyA  out  1  rd_addrA matches outstanding load destination
  busyB  out  1  rd_addrB matches outstanding load destination
  wr_conflict  out  1  registered one-cycle pulse: ALU write dropped
REQ-003 One clock, clk; reset is synchronous and active-high.

Function
REQ-004 Storage SHALL be 2**PW registers of W bits; reads combinational; writes on clk rising edge.
REQ-005 Register 0 SHALL read constant 0 and register 1 constant 1; writes to them SHALL be discarded.
REQ-006 Load FSM SHALL have states IDLE and WAIT; latched pend_addr valid only in WAIT.
REQ-007 IDLE: ld_issue=1 -> WAIT, pend_addr<=ld_addr; ld_valid in IDLE SHALL be ignored (no write).
REQ-008 WAIT: ld_valid=1 -> writes ld_data to pend_addr; -> IDLE unless ld_issue=1 same cycle, then stays WAIT with pend_addr<=ld_addr (back-to-back).
REQ-009 issue_ready SHALL be (state==IDLE) | ld_valid; ld_issue with issue_ready=0 SHALL be ignored.
REQ-010 ld_issue to address 0 or 1 SHALL be accepted normally; its returned data discarded; busyA/B never asserted for addresses 0/1.
REQ-011 busyA = (state==WAIT) & (rd_addrA==pend_addr) & pend_addr>1; busyB likewise; combinational.
REQ-012 ALU write with wr_en=1 SHALL commit unless wr_addr<2 or (state==WAIT & wr_addr==pend_addr).
REQ-013 An ALU write dropped for pending-address match SHALL assert wr_conflict for exactly the next cycle; writes to 0/1 SHALL NOT assert it.
REQ-014 Same-cycle load return and ALU write to the same address: load SHALL win (covered by REQ-012); different addresses: both SHALL commit.
REQ-015 ded_out SHALL always equal register DED as read through port semantics of REQ-016/017.
REQ-016 Without forwarding, reads SHALL return pre-edge contents; a write is visible the cycle after it commits.
REQ-017 No arithmetic; all data paths exactly W bits, no extension or truncation.

Reset
REQ-018 reset=1 at a clk edge SHALL clear registers 2..2**PW-1 to 0, state to IDLE, wr_conflict to 0.
REQ-019 After reset: datA/datB/ded_out read 0 (or 1 for address 1), busyA/B=0, issue_ready=1.
REQ-020 reset SHALL override any same-cycle write, ld_issue or ld_valid; an outstanding load is abandoned and its later ld_valid ignored.

Configuration
REQ-021 Macro REG_BANK_FWD_EN SHALL select write forwarding.
REQ-022 Defined: datA_out/datB_out/ded_out SHALL return the value being committed this cycle (load data over ALU data) when the read address matches a committing write; constants unaffected; dropped writes never forwarded.
REQ-023 Undefined: behaviour per REQ-016; no forwarding logic present.

Verification
REQ-024 Reset, then read all addresses -> 0,1,0,0,...; issue_ready=1, busyA/B=0, wr_conflict=0.
REQ-025 wr_en, wr_addr=5, dat_in=0xA5; same cycle rd_addrA=5 -> 0x00 (0xA5 with FWD_EN); next cycle 0xA5; write to addr 1 -> still reads 1.
REQ-026 ld_issue addr=2; next cycle rd_addrA=2 -> busyA=1, issue_ready=0; ld_valid ld_data=0x3C -> ded_out=0x3C next cycle, busyA=0.
REQ-027 In WAIT pend=4: wr_en addr=4 data 0x11 -> dropped, wr_conflict=1 one cycle; ld_valid 0x22 -> reg4=0x22; wr_en addr=6 with ld_valid -> both commit.
REQ-028 WAIT pend=3: ld_valid 0x55 plus ld_issue addr=7 same cycle -> reg3=0x55, stays WAIT, busy on 7, not 3.
REQ-029 WAIT pend=5, assert reset -> IDLE, reg5=0; later ld_valid 0x99 -> ignored, reg5 stays 0.
